uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Byte FIFO feeding a UART transmitter. Bytes are queued in a circular
// buffer and handed to the transmitter one at a time. A small handshake
// FSM issues a one-cycle tx_begin and then follows the transmitter's busy
// flag. tx_data is registered at the pop edge and holds for the whole frame.

module uart_tx_fifo #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              enable,
  input  logic              clr_ovf,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_begin,
  output logic              tx_en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              drained
);

  localparam int              DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ZERO_C = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] CNT_ONE_C  = (ADDR_W+1)'(1'b1);
  localparam logic [ADDR_W-1:0] PTR_ZERO_C = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE_C  = ADDR_W'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_START    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_SENDING  = 2'd3
  } state_t;

  logic [7:0]        mem_r [0:DEPTH-1];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic [7:0]        tx_data_r;
  logic              tx_begin_r;
  logic              overflow_r;
  state_t            state_r;
  state_t            state_next_s;

  logic              full_s;
  logic              empty_s;
  logic              pop_s;
  logic              wr_accept_s;
  logic              wr_drop_s;

  // Occupancy flags and the push/pop/drop decisions for this cycle.
  always_comb begin
    full_s      = (count_r == DEPTH_C);
    empty_s     = (count_r == CNT_ZERO_C);
    // A pop only happens from IDLE; the head byte moves into tx_data_r.
    pop_s       = (state_r == ST_IDLE) && !empty_s && enable;
    // A pop in the same cycle frees a slot, so a write at full still lands.
    wr_accept_s = wr_en && (!full_s || pop_s);
    wr_drop_s   = wr_en && full_s && !pop_s;
  end

  // Handshake FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) begin
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        state_next_s = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (tx_busy) begin
          state_next_s = ST_SENDING;
        end else if (!enable) begin
          // Transmitter never picked the byte up and permission was
          // withdrawn: give up on this byte.
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT_ACK;
        end
      end
      ST_SENDING: begin
        // enable is deliberately ignored here so a frame is never cut short.
        if (!tx_busy) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_SENDING;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register; tx_begin is registered so it is high exactly while in START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      tx_begin_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      tx_begin_r <= (state_next_s == ST_START);
    end
  end

  // Read/write pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO_C;
      rd_ptr_r <= PTR_ZERO_C;
      count_r  <= CNT_ZERO_C;
    end else begin
      if (wr_accept_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      case ({wr_accept_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE_C;
        2'b01:   count_r <= count_r - CNT_ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Output byte register, loaded only on a pop so it is stable for the frame.
  // At full with a simultaneous push, wr_ptr equals rd_ptr; the read here
  // sees the old head because the array update is non-blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data_r <= 8'h00;
    end else if (pop_s) begin
      tx_data_r <= mem_r[rd_ptr_r];
    end
  end

  // Sticky overflow; a dropped write wins over a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (wr_drop_s) begin
      overflow_r <= 1'b1;
    end else if (clr_ovf) begin
      overflow_r <= 1'b0;
    end
  end

  assign tx_data  = tx_data_r;
  assign tx_begin = tx_begin_r;
  assign tx_en    = enable;
  assign full     = full_s;
  assign empty    = empty_s;
  assign count    = count_r;
  assign overflow = overflow_r;
  assign drained  = empty_s && (state_r == ST_IDLE) && !tx_busy;

endmodule
